// File: rtl/rrf_alloc_pkg.sv
// Shared sizing constants for the rename-register allocator and its interface.
package rrf_alloc_pkg;
  localparam int unsigned RRF_NUM_DEF = 64;
  localparam int unsigned RRF_SEL_DEF = 6;
endpackage

// File: rtl/rrf_alloc_if.sv
// Dispatch-side allocation handshake between the DP stage and the RRF allocator.
interface rrf_alloc_if
  import rrf_alloc_pkg::*;
#(
    parameter int unsigned RRF_SEL = RRF_SEL_DEF
);
    logic               dp_req1_i;
    logic               dp_req2_i;
    logic               stall_o;
    logic               alloc_en1_o;
    logic [RRF_SEL-1:0] alloc_tag1_o;
    logic               alloc_en2_o;
    logic [RRF_SEL-1:0] alloc_tag2_o;

    modport master (
        output dp_req1_i, dp_req2_i,
        input  stall_o, alloc_en1_o, alloc_tag1_o, alloc_en2_o, alloc_tag2_o
    );

    modport slave (
        input  dp_req1_i, dp_req2_i,
        output stall_o, alloc_en1_o, alloc_tag1_o, alloc_en2_o, alloc_tag2_o
    );
endinterface

// File: rtl/rrf_alloc.sv
// RRF free-window allocator: hands out up to two tags per cycle, reclaims on commit,
// and rewinds the allocation pointer on flush.
module rrf_alloc
  import rrf_alloc_pkg::*;
#(
    parameter int unsigned RRF_NUM = RRF_NUM_DEF,
    parameter int unsigned RRF_SEL = RRF_SEL_DEF
) (
    input  logic               clk,
    input  logic               reset,
    rrf_alloc_if.slave         dp,
    input  logic [1:0]         com_num_i,
    output logic [RRF_SEL-1:0] com_ptr_o,
    input  logic               flush_i,
    input  logic [RRF_SEL-1:0] flush_tag_i,
    output logic [RRF_SEL:0]   freenum_o
);
    localparam int unsigned FREE_W = RRF_SEL + 1;

    logic [RRF_SEL-1:0] alloc_ptr;
    logic [RRF_SEL-1:0] com_ptr;
    logic [FREE_W-1:0]  freenum;

    logic [1:0]         req_cnt;
    logic [1:0]         alloc_num;
    logic               stall;
    logic [RRF_SEL-1:0] com_ptr_n;
    logic [RRF_SEL-1:0] flush_dist;
    logic [RRF_SEL-1:0] alloc_ptr_next;
    logic [FREE_W-1:0]  freenum_next;

    always_comb begin
        req_cnt  = {1'b0, dp.dp_req1_i} + {1'b0, dp.dp_req2_i};
        stall    = (FREE_W'(req_cnt) > freenum) | flush_i;
        alloc_num = {1'b0, dp.dp_req1_i & ~stall} + {1'b0, dp.dp_req2_i & ~stall};
        com_ptr_n = com_ptr + RRF_SEL'(com_num_i);
        flush_dist = flush_tag_i - com_ptr_n;

        alloc_ptr_next = alloc_ptr + RRF_SEL'(alloc_num);
        freenum_next   = freenum - FREE_W'(alloc_num) + FREE_W'(com_num_i);
        if (flush_i) begin
            // Surviving in-flight span is com_ptr_n..flush_tag_i-1; zero span means all free.
            alloc_ptr_next = flush_tag_i;
            freenum_next   = FREE_W'(RRF_NUM) - FREE_W'(flush_dist);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr <= '0;
            com_ptr   <= '0;
            freenum   <= FREE_W'(RRF_NUM);
        end else begin
            alloc_ptr <= alloc_ptr_next;
            com_ptr   <= com_ptr_n;
            freenum   <= freenum_next;
        end
    end

    assign dp.stall_o      = stall;
    assign dp.alloc_en1_o  = dp.dp_req1_i & ~stall;
    assign dp.alloc_en2_o  = dp.dp_req2_i & ~stall;
    assign dp.alloc_tag1_o = alloc_ptr;
    assign dp.alloc_tag2_o = dp.dp_req1_i ? alloc_ptr + RRF_SEL'(1) : alloc_ptr;
    assign com_ptr_o       = com_ptr;
    assign freenum_o       = freenum;
endmodule

// File: tb/tb_rrf_alloc.sv
// Directed scoreboard bench for rrf_alloc: fill, wrap-around, slot-2-only,
// commit-vs-stall, flush rewind and reset-during-flush scenarios.
module tb_rrf_alloc;
    localparam int unsigned NUM = 64;
    localparam int unsigned SEL = 6;

    typedef enum int unsigned {S_STALL, S_EN1, S_TAG1, S_EN2, S_TAG2, S_COMPTR, S_FREE} sel_e;
    typedef struct {
        sel_e        sel;
        string       name;
        logic [31:0] val;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     com_num_i;
    logic [SEL-1:0] com_ptr_o;
    logic           flush_i;
    logic [SEL-1:0] flush_tag_i;
    logic [SEL:0]   freenum_o;

    int unsigned checks = 0;
    int unsigned failures = 0;
    exp_t sb[$];

    rrf_alloc_if #(.RRF_SEL(SEL)) dp_if ();

    rrf_alloc #(.RRF_NUM(NUM), .RRF_SEL(SEL)) dut (
        .clk        (clk),
        .reset      (reset),
        .dp         (dp_if.slave),
        .com_num_i  (com_num_i),
        .com_ptr_o  (com_ptr_o),
        .flush_i    (flush_i),
        .flush_tag_i(flush_tag_i),
        .freenum_o  (freenum_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Commit count must never exceed the in-flight population.
    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            if (com_num_i == 2'd3 || 32'(com_num_i) > NUM - 32'(freenum_o)) begin
                checks++;
                assert (1'b0) else begin
                    failures++;
                    $error("FAIL illegal_com observed=%0d expected<=%0d", com_num_i, NUM - 32'(freenum_o));
                end
            end
        end
    end

    function automatic logic [31:0] obs(sel_e s);
        case (s)
            S_STALL:  return 32'(dp_if.stall_o);
            S_EN1:    return 32'(dp_if.alloc_en1_o);
            S_TAG1:   return 32'(dp_if.alloc_tag1_o);
            S_EN2:    return 32'(dp_if.alloc_en2_o);
            S_TAG2:   return 32'(dp_if.alloc_tag2_o);
            S_COMPTR: return 32'(com_ptr_o);
            default:  return 32'(freenum_o);
        endcase
    endfunction

    task automatic push(input sel_e s, input string name, input int unsigned v);
        exp_t e;
        e.sel  = s;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [31:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic drive(input logic r1, input logic r2, input logic [1:0] cn,
                         input logic fl, input logic [SEL-1:0] ft);
        dp_if.dp_req1_i = r1;
        dp_if.dp_req2_i = r2;
        com_num_i       = cn;
        flush_i         = fl;
        flush_tag_i     = ft;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, '0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, '0);

        // Reset state
        do_reset();
        push(S_COMPTR, "rst_comptr", 0);
        push(S_FREE, "rst_free", 64);
        push(S_TAG1, "rst_tag1", 0);
        push(S_STALL, "rst_stall", 0);
        push(S_EN1, "rst_en1", 0);
        check();

        // Fill all 64 entries two at a time
        for (int i = 0; i < 32; i++) begin
            drive(1, 1, 0, 0, '0);
            push(S_STALL, $sformatf("fill_stall_c%0d", i), 0);
            push(S_EN1, $sformatf("fill_en1_c%0d", i), 1);
            push(S_EN2, $sformatf("fill_en2_c%0d", i), 1);
            push(S_TAG1, $sformatf("fill_tag1_c%0d", i), 2 * i);
            push(S_TAG2, $sformatf("fill_tag2_c%0d", i), 2 * i + 1);
            check();
            tick();
            push(S_FREE, $sformatf("fill_free_c%0d", i), 64 - 2 * (i + 1));
            check();
        end
        drive(1, 1, 0, 0, '0);
        push(S_STALL, "full_stall", 1);
        push(S_EN1, "full_en1", 0);
        push(S_EN2, "full_en2", 0);
        check();
        tick();
        push(S_FREE, "full_free_hold", 0);
        check();

        // Wrap-around: bring both pointers to 63
        do_reset();
        for (int i = 0; i < 31; i++) begin
            drive(1, 1, 0, 0, '0);
            tick();
        end
        drive(1, 0, 0, 0, '0);
        tick();
        push(S_FREE, "wrap_free_after_alloc", 1);
        push(S_TAG1, "wrap_allocptr_63", 63);
        check();
        for (int i = 0; i < 63; i++) begin
            drive(0, 0, 1, 0, '0);
            tick();
        end
        drive(0, 0, 0, 0, '0);
        push(S_COMPTR, "wrap_comptr_63", 63);
        push(S_FREE, "wrap_free_empty", 64);
        check();
        drive(1, 1, 0, 0, '0);
        push(S_TAG1, "wrap_tag1", 63);
        push(S_TAG2, "wrap_tag2", 0);
        push(S_STALL, "wrap_stall", 0);
        check();
        tick();
        drive(0, 0, 0, 0, '0);
        push(S_FREE, "wrap_free_62", 62);
        push(S_TAG1, "wrap_allocptr_1", 1);
        check();

        // Slot 2 only at alloc_ptr 5
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, '0);
            tick();
        end
        drive(0, 1, 0, 0, '0);
        push(S_TAG1, "s2_allocptr_5", 5);
        push(S_TAG2, "s2_tag2", 5);
        push(S_EN1, "s2_en1", 0);
        push(S_EN2, "s2_en2", 1);
        push(S_STALL, "s2_stall", 0);
        check();
        tick();
        drive(0, 0, 0, 0, '0);
        push(S_TAG1, "s2_allocptr_6", 6);
        push(S_FREE, "s2_free", 57);
        check();

        // Commit does not relieve a same-cycle stall
        for (int i = 0; i < 28; i++) begin
            drive(1, 1, 0, 0, '0);
            tick();
        end
        drive(1, 1, 2, 0, '0);
        push(S_FREE, "cs_free_1", 1);
        push(S_STALL, "cs_stall", 1);
        push(S_EN1, "cs_en1_blocked", 0);
        push(S_EN2, "cs_en2_blocked", 0);
        check();
        tick();
        drive(1, 1, 0, 0, '0);
        push(S_FREE, "cs_free_3", 3);
        push(S_COMPTR, "cs_comptr", 1);
        push(S_STALL, "cs_stall_clear", 0);
        push(S_EN1, "cs_en1", 1);
        push(S_EN2, "cs_en2", 1);
        push(S_TAG1, "cs_tag1", 62);
        push(S_TAG2, "cs_tag2", 63);
        check();
        tick();
        drive(0, 0, 0, 0, '0);
        push(S_FREE, "cs_free_after", 1);
        push(S_TAG1, "cs_allocptr_0", 0);
        check();

        // Flush rewind: com_ptr 10, alloc_ptr 30
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 0, '0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 2, 0, '0);
            tick();
        end
        drive(0, 0, 0, 0, '0);
        push(S_COMPTR, "fl_pre_comptr", 10);
        push(S_TAG1, "fl_pre_allocptr", 30);
        push(S_FREE, "fl_pre_free", 44);
        check();
        drive(1, 1, 1, 1, 6'd20);
        push(S_STALL, "fl_stall", 1);
        push(S_EN1, "fl_en1", 0);
        push(S_EN2, "fl_en2", 0);
        check();
        tick();
        drive(1, 0, 0, 0, '0);
        push(S_COMPTR, "fl_comptr", 11);
        push(S_FREE, "fl_free", 55);
        push(S_TAG1, "fl_tag1", 20);
        push(S_EN1, "fl_en1_after", 1);
        check();
        tick();
        drive(0, 0, 0, 0, '0);
        push(S_FREE, "fl_free_after", 54);
        check();

        // Flush back to the post-commit pointer empties the window
        drive(0, 0, 2, 1, 6'd13);
        tick();
        drive(0, 0, 0, 0, '0);
        push(S_FREE, "flc_free", 64);
        push(S_COMPTR, "flc_comptr", 13);
        push(S_TAG1, "flc_allocptr", 13);
        check();

        // Reset wins over a concurrent flush/commit/allocate
        drive(1, 1, 0, 0, '0);
        tick();
        reset = 1'b1;
        drive(1, 1, 2, 1, 6'd40);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, '0);
        push(S_COMPTR, "rf_comptr", 0);
        push(S_FREE, "rf_free", 64);
        push(S_TAG1, "rf_tag1", 0);
        check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rrf_alloc.md
# rrf_alloc

Rename-register allocator for the DP stage. Tracks which RRF entries are free as a circular window between a commit pointer and an allocation pointer. Hands out up to two destination rrftags per cycle to the dispatcher; these drive the RRF allocate port. Reclaims entries as COM retires instructions, and rewinds the allocation pointer on a pipeline flush.

## Interface
Parameters:
- `RRF_NUM`, default `` `RRF_NUM `` (64): number of RRF entries; must be a power of two.
- `RRF_SEL`, default `` `RRF_SEL `` (6): log2(RRF_NUM), the tag width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `dp_req1_i`  in  1  dispatch slot 1 needs a destination entry.
- `dp_req2_i`  in  1  dispatch slot 2 needs a destination entry.
- `stall_o`  out  1  not enough free entries for this cycle's requests; nothing is allocated.
- `alloc_en1_o`  out  1  slot 1 allocation accepted this cycle.
- `alloc_tag1_o`  out  RRF_SEL  tag for slot 1.
- `alloc_en2_o`  out  1  slot 2 allocation accepted this cycle.
- `alloc_tag2_o`  out  RRF_SEL  tag for slot 2.
- `com_num_i`  in  2  entries retired this cycle (0..2), oldest first.
- `com_ptr_o`  out  RRF_SEL  oldest in-flight tag; feeds RRF `completed_dst_rrftag_i`.
- `flush_i`  in  1  flush: discard all entries at and after `flush_tag_i`.
- `flush_tag_i`  in  RRF_SEL  first tag to reclaim on flush.
- `freenum_o`  out  RRF_SEL+1  current free-entry count (0..RRF_NUM).

## Operation
- State registers:
  - `alloc_ptr` (RRF_SEL): next tag to allocate.
  - `com_ptr` (RRF_SEL): oldest in-flight tag.
  - `freenum` (RRF_SEL+1): free-entry count.
- Request count `req_cnt = dp_req1_i + dp_req2_i`.
- Stall rule: `stall_o = (req_cnt > freenum) | flush_i`. Combinational on the current `freenum` only; same-cycle commits do not relieve a stall.
- Enables:
  - `alloc_en1_o = dp_req1_i & ~stall_o`.
  - `alloc_en2_o = dp_req2_i & ~stall_o`.
- Tags:
  - `alloc_tag1_o = alloc_ptr`.
  - `alloc_tag2_o = dp_req1_i ? alloc_ptr+1 : alloc_ptr`, mod RRF_NUM.
  - Tags are driven even when the enable is low; consumers qualify them with the enables.
- `alloc_num = alloc_en1_o + alloc_en2_o`.
- Normal update (`flush_i` = 0):
  - `alloc_ptr += alloc_num`.
  - `com_ptr += com_num_i`.
  - `freenum = freenum - alloc_num + com_num_i`.
  - All arithmetic is modulo RRF_NUM, except `freenum`, which is exact in RRF_SEL+1 bits.
- Flush update (`flush_i` = 1; overrides allocation, commit still applies):
  - `com_ptr_n = com_ptr + com_num_i`.
  - `alloc_ptr <= flush_tag_i`.
  - `com_ptr <= com_ptr_n`.
  - `freenum <= RRF_NUM - ((flush_tag_i - com_ptr_n) mod RRF_NUM)`.
  - `flush_tag_i == com_ptr_n` means everything was squashed: `freenum = RRF_NUM`.
- Full window: `freenum == 0` with `alloc_ptr == com_ptr`.
- Empty window: `freenum == RRF_NUM` with `alloc_ptr == com_ptr`. `freenum` alone disambiguates full from empty; the pointers are never compared.
- Illegal input, `com_num_i` greater than the in-flight count (`RRF_NUM - freenum`): behaviour undefined. The bench flags it with an assertion.
- `com_num_i == 3` is illegal.

## Timing
- Reset values:
  - `alloc_ptr = 0`, `com_ptr = 0`, `freenum = RRF_NUM`.
  - Outputs: `com_ptr_o = 0`, `freenum_o = RRF_NUM`, `alloc_tag1_o = 0`.
  - `alloc_tag2_o`, `alloc_en*`, `stall_o` follow the request inputs combinationally.
- Reset overrides flush, commit and allocation in the same cycle.
- Allocation latency is zero: tags and enables are valid in the request cycle. Pointers advance at that cycle's clock edge.
- Commits take effect at the clock edge. Freed entries are allocatable from the next cycle.
- Flush takes one cycle: `stall_o` is high during the flush cycle. The rewound `alloc_ptr` is used from the next cycle.
- `com_ptr_o` and `freenum_o` are registered outputs.

## Structure
- `RRF_NUM` and `RRF_SEL` come from `consts/Consts.v`; no new constants are needed.
- Single module, no sub-modules. The modulo pointer increment is plain RRF_SEL-bit wrap-around addition.
- Instantiated beside the `Rrf` module: `alloc_en1_o`/`alloc_tag1_o` drive its allocate port, and `com_ptr_o` drives its commit-read port.

## Test plan
- Reset, then `dp_req1_i = dp_req2_i = 1` for 32 cycles:
  - Tag pairs (0,1), (2,3) … (62,63).
  - `freenum_o` reaches 0.
  - In cycle 33 `stall_o = 1` and both enables are 0.
- Wrap-around:
  - Allocate 63, commit 63 one entry per cycle; `alloc_ptr = com_ptr = 63`.
  - Request both slots: tags (63,0), `alloc_ptr -> 1`, `freenum_o` 64 -> 62.
- Slot 2 only, `alloc_ptr = 5`: `alloc_tag2_o = 5`, `alloc_ptr -> 6`.
- Simultaneous commit and allocate with `freenum = 1`:
  - Request 2 with `com_num_i = 2`.
  - `stall_o = 1` that cycle; next cycle `freenum_o = 3` and the request is accepted.
- Flush:
  - State: `com_ptr = 10`, `alloc_ptr = 30`.
  - Apply `flush_tag_i = 20` with `com_num_i = 1`.
  - Next cycle: `alloc_ptr = 20`, `com_ptr_o = 11`, `freenum_o = 55`. A request then gets tag 20.
- Flush to the commit pointer: `flush_tag_i == com_ptr_n` gives `freenum_o = 64`. Reset asserted during a flush leaves all state at its reset values.
